// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
`default_nettype none
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHK    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // States in which the loader is waiting on the byte stream mid-frame.
  function automatic logic is_timed(input state_e s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CHK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: expired_o flags the cycle on which TIMEOUT idle cycles complete.
`default_nettype none
module loader_timeout #(
  parameter int TIMEOUT = 65535
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CW'(1);
    if (clr_i || !en_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires while the last allowed idle cycle is in progress, so the abort lands on that edge.
  assign expired_o = en_i && !clr_i && (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
// Framed byte-stream loader: assembles LE words, writes imem, verifies an XOR checksum.
`default_nettype none
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            chk_q, chk_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  xfer;
  logic                  expired;

  assign xfer = in_valid && in_ready;

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .en_i      (is_timed(state_q)),
    .clr_i     (xfer),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (xfer && in_data == SYNC_BYTE) begin
          state_d = S_LEN_HI;
          chk_d   = '0;
          idx_d   = '0;
          addr_d  = '0;
          words_d = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          chk_d       = chk_q ^ in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = {len_q[15:8], in_data};
          chk_d = chk_q ^ in_data;
          if (32'(len_d) > MAX_WORDS) begin
            state_d = S_ERR;
          end else if (len_d == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          data_d[{idx_q, 3'b000} +: 8] = in_data;
          chk_d = chk_q ^ in_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        words_d = words_q + (ADDR_WIDTH + 1)'(1);
        state_d = (32'(words_d) == 32'(len_q)) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (xfer) begin
          state_d = (in_data == chk_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Expiry only occurs in a timed state with no transfer, so it never races a byte.
    if (expired) begin
      state_d = S_ERR;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      chk_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      words_q <= words_d;
    end
  end

  // Gating with reset keeps the stream stalled while the loader is held in reset.
  assign in_ready     = reset && (state_q != S_WRITE);
  assign mem_wen      = (state_q == S_WRITE);
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign cpu_hold     = (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);
  assign words_loaded = words_q;

endmodule
`default_nettype wire
